acq_search_ctrl: RTL

//  Sequences one tracking channel through a 2-D acquisition sweep (Doppler bin x code shift).

---
 rtl/acq_search_ctrl_pkg.sv | 18 +
 rtl/acq_search_ctrl_if.sv | 15 +
 rtl/acq_peak_tracker.sv | 37 +++
 rtl/acq_search_ctrl.sv | 142 ++++++++++++++
 4 files changed

// File: rtl/acq_search_ctrl_pkg.sv
// Shared types for the acquisition sweep controller: FSM state encoding and a counter-width helper.
package acq_search_ctrl_pkg;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_SEEK    = 3'd1,
    ST_SETTLE  = 3'd2,
    ST_DWELL   = 3'd3,
    ST_COMPARE = 3'd4,
    ST_DONE    = 3'd5
  } acq_state_e;

  // Bits needed to count 0..n-1, never less than one.
  function automatic int cnt_w(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/acq_search_ctrl_if.sv
// Channel-side link of the sweep controller: retune outputs toward the channel, dump strobe back.
interface acq_search_ctrl_if #(
  parameter int DOP_W   = 16,
  parameter int SHIFT_W = 15,
  parameter int PWR_W   = 38
);
  logic               seek_en;
  logic [SHIFT_W-1:0] seek_target;
  logic [DOP_W-1:0]   doppler;
  logic               i2q2_valid;
  logic [PWR_W-1:0]   i2q2_prompt;

  modport master (output seek_en, seek_target, doppler, input i2q2_valid, i2q2_prompt);
  modport slave  (input seek_en, seek_target, doppler, output i2q2_valid, i2q2_prompt);
endinterface

// File: rtl/acq_peak_tracker.sv
// Running maximum of prompt power over a sweep; the first cell always seeds the peak, ties keep the earlier cell.
module acq_peak_tracker #(
  parameter int DOP_W   = 16,
  parameter int SHIFT_W = 15,
  parameter int PWR_W   = 38
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               clear,
  input  logic               sample_en,
  input  logic [PWR_W-1:0]   sample_power,
  input  logic [DOP_W-1:0]   sample_doppler,
  input  logic [SHIFT_W-1:0] sample_shift,
  output logic               better,
  output logic [PWR_W-1:0]   best_power,
  output logic [DOP_W-1:0]   best_doppler,
  output logic [SHIFT_W-1:0] best_shift
);
  logic seen;

  assign better = !seen || (sample_power > best_power);

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (reset || clear) begin
      seen         <= 1'b0;
      best_power   <= '0;
      best_doppler <= '0;
      best_shift   <= '0;
    end else if (sample_en && better) begin
      seen         <= 1'b1;
      best_power   <= sample_power;
      best_doppler <= sample_doppler;
      best_shift   <= sample_shift;
    end
  end
endmodule

// File: rtl/acq_search_ctrl.sv
// Steps one tracking channel through a Doppler-bin x code-shift sweep and reports the peak cell.
// Optional feature: define ACQ_EARLY_EXIT_EN to end the sweep at the first cell above threshold.
module acq_search_ctrl
  import acq_search_ctrl_pkg::*;
#(
  parameter int DOP_W        = 16,
  parameter int SHIFT_W      = 15,
  parameter int PWR_W        = 38,
  parameter int NUM_BINS     = 21,
  parameter int NUM_SHIFTS   = 2046,
  parameter int CODE_STEP    = 1,
  parameter int SETTLE_DUMPS = 1
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic               abort,
  input  logic [DOP_W-1:0]   dop_min,
  input  logic [DOP_W-1:0]   dop_step,
  input  logic [PWR_W-1:0]   threshold,
  acq_search_ctrl_if.master  chan,
  output logic               busy,
  output logic               done,
  output logic               found,
  output logic [DOP_W-1:0]   best_doppler,
  output logic [SHIFT_W-1:0] best_shift,
  output logic [PWR_W-1:0]   best_power
);
  localparam int BIN_W       = cnt_w(NUM_BINS);
  localparam int SHF_W       = cnt_w(NUM_SHIFTS);
  localparam int SET_W       = cnt_w(SETTLE_DUMPS);
  localparam int SETTLE_LAST = (SETTLE_DUMPS > 0) ? SETTLE_DUMPS - 1 : 0;

  if (NUM_BINS < 1 || NUM_SHIFTS < 1 ||
      longint'(NUM_SHIFTS) * longint'(CODE_STEP) > (longint'(1) << SHIFT_W)) begin : g_cfg_check
    $error("acq_search_ctrl: sweep dimensions do not fit seek_target");
  end

  acq_state_e         state, state_nx;
  logic [BIN_W-1:0]   bin_q;
  logic [SHF_W-1:0]   shift_q;
  logic [SET_W-1:0]   settle_q;
  logic [DOP_W-1:0]   dop_step_q, doppler_q;
  logic [SHIFT_W-1:0] target_q;
  logic [PWR_W-1:0]   threshold_q, sample_q, peak_next;
  logic               found_q, better;
  logic               last_shift, last_bin, settle_last, early_hit, start_sweep, abort_now;

  assign last_shift  = (shift_q == SHF_W'(NUM_SHIFTS - 1));
  assign last_bin    = (bin_q == BIN_W'(NUM_BINS - 1));
  assign settle_last = (settle_q == SET_W'(SETTLE_LAST));
  assign abort_now   = abort && (state != ST_IDLE);
  assign start_sweep = (state == ST_IDLE) && start && !abort;
  assign peak_next   = better ? sample_q : best_power;

`ifdef ACQ_EARLY_EXIT_EN
  assign early_hit = (sample_q > threshold_q);
`else
  assign early_hit = 1'b0;
`endif

  // NOTE: next state gets its default before the case so no path leaves it unassigned (no latch).
  always_comb begin
    state_nx = state;
    unique case (state)
      ST_IDLE:    if (start_sweep) state_nx = ST_SEEK;
      ST_SEEK:    state_nx = (SETTLE_DUMPS == 0) ? ST_DWELL : ST_SETTLE;
      ST_SETTLE:  if (chan.i2q2_valid && settle_last) state_nx = ST_DWELL;
      ST_DWELL:   if (chan.i2q2_valid) state_nx = ST_COMPARE;
      ST_COMPARE: state_nx = (early_hit || (last_shift && last_bin)) ? ST_DONE : ST_SEEK;
      ST_DONE:    state_nx = ST_IDLE;
      default:    state_nx = ST_IDLE;
    endcase
    if (abort_now) state_nx = ST_IDLE;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= ST_IDLE;
      bin_q       <= '0;
      shift_q     <= '0;
      settle_q    <= '0;
      dop_step_q  <= '0;
      doppler_q   <= '0;
      target_q    <= '0;
      threshold_q <= '0;
      sample_q    <= '0;
      found_q     <= 1'b0;
    end else begin
      state <= state_nx;
      if (start_sweep) begin
        dop_step_q  <= dop_step;
        threshold_q <= threshold;
        doppler_q   <= dop_min;
        target_q    <= '0;
        bin_q       <= '0;
        shift_q     <= '0;
        found_q     <= 1'b0;
      end
      // Dumps seen while seek_en is high are stale and never reach SETTLE/DWELL.
      if (state == ST_SEEK) settle_q <= '0;
      else if (state == ST_SETTLE && chan.i2q2_valid)
        settle_q <= settle_last ? '0 : settle_q + SET_W'(1);
      if (state == ST_DWELL && chan.i2q2_valid) sample_q <= chan.i2q2_prompt;
      if (state == ST_COMPARE && state_nx == ST_SEEK) begin
        if (last_shift) begin
          shift_q   <= '0;
          target_q  <= '0;
          bin_q     <= bin_q + BIN_W'(1);
          doppler_q <= doppler_q + dop_step_q;
        end else begin
          shift_q  <= shift_q + SHF_W'(1);
          target_q <= target_q + SHIFT_W'(CODE_STEP);
        end
      end
      if (state == ST_COMPARE && state_nx == ST_DONE) found_q <= (peak_next > threshold_q);
      if (abort_now) found_q <= 1'b0;
    end
  end

  acq_peak_tracker #(.DOP_W(DOP_W), .SHIFT_W(SHIFT_W), .PWR_W(PWR_W)) u_peak (
    .clk            (clk),
    .reset          (reset),
    .clear          (start_sweep),
    .sample_en      (state == ST_COMPARE),
    .sample_power   (sample_q),
    .sample_doppler (doppler_q),
    .sample_shift   (target_q),
    .better         (better),
    .best_power     (best_power),
    .best_doppler   (best_doppler),
    .best_shift     (best_shift)
  );

  assign chan.seek_en     = (state == ST_SEEK);
  assign chan.seek_target = target_q;
  assign chan.doppler     = doppler_q;
  assign busy             = (state == ST_SEEK) || (state == ST_SETTLE) ||
                            (state == ST_DWELL) || (state == ST_COMPARE);
  assign done             = (state == ST_DONE);
  assign found            = found_q;
endmodule
